restoring_divider: RTL and testbench
====================================

Name: restoring_divider

Overview:
- Sequential unsigned divider; the inverse operation of the team's serial multiplier, using the same narrow word-serial interface.
- Accepts a 2·WIDTH-bit dividend and a WIDTH-bit divisor over successive cycles on `data_in`.
- Runs one restoring iteration per clock, then returns quotient and remainder word-serially on `data_out`.
- Intended to sit beside the multiplier so a multiplier product can be fed straight back in for checking.

Parameters:
- WIDTH, 5, operand word width (divisor, each dividend half, quotient and remainder).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  launches an operation; sampled only in IDLE.
- data_in  input  WIDTH  serial operand words.
- data_out  output  WIDTH  quotient, then remainder; 0 otherwise.
- done  output  1  high for exactly the quotient cycle.
- busy  output  1  high from the cycle after start is accepted through the remainder cycle.
- ovf  output  1  quotient overflow: dividend_hi >= divisor, divisor nonzero.
- dvz  output  1  divide by zero.

Behaviour:
- Reset (rst=0, any time, including mid-operation): state IDLE; data_out=0, done=0, busy=0, ovf=0, dvz=0; internal registers cleared.
- Cycle S, IDLE with start=1: capture data_in as divisor D.
  - start in any other state is ignored.
  - start in IDLE also clears ovf and dvz.
- S+1, LOAD_HI: capture dividend high word H.
- S+2, LOAD_LO: capture dividend low word L.
- S+3, CHECK:
  - If D==0: dvz=1, go to OUT_Q.
  - Else if H>=D: ovf=1, go to OUT_Q.
  - Else init R={1'b0,H} (WIDTH+1 bits), Q=L, count=0, go to ITER.
- ITER (WIDTH cycles, S+4 .. S+3+WIDTH), each cycle:
  - Shift {R,Q} left by 1.
  - T = R_shifted − {1'b0,D}, computed in WIDTH+2 bits.
  - If T is non-negative: R=T, Q[0]=1. Else R unchanged (restored), Q[0]=0.
  - After the WIDTH-th iteration go to OUT_Q.
  - Invariant: R < D throughout.
- OUT_Q (S+4+WIDTH normally; S+4 on the skip path): done=1, data_out=quotient.
  - On dvz or ovf, quotient is forced to all-ones and remainder to H.
- OUT_R (next cycle): done=0, data_out=remainder (R[WIDTH-1:0]), then go to IDLE.
- Latency for WIDTH=5: quotient appears 9 cycles after the start cycle; back-to-back start is accepted in the cycle after OUT_R.
- ovf and dvz are mutually exclusive. They hold their value from CHECK until the next accepted start or reset.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - State encoding: IDLE, LOAD_HI, LOAD_LO, CHECK, ITER, OUT_Q, OUT_R.
  - Default WIDTH constant.
  - Iteration-counter width, clog2(WIDTH+1).
- Natural split, matching the multiplier's structure:
  - divider_datapath: D/R/Q registers, subtractor, shift logic, output mux.
  - divider_controller: FSM and counter, producing load/shift/select strobes and done/busy.
  - restoring_divider is a thin top that wires the two.

Test Plan:
- D=13, H=6, L=9 (dividend 201) → at S+9: done=1, data_out=15. At S+10: data_out=6. ovf=0, dvz=0.
- D=31, H=30, L=31 (dividend 991, maximum legal quotient) → quotient 31, remainder 30, no flags.
- D=0, H=3, L=7 → dvz=1 at S+4 with done=1, data_out=31. Next cycle data_out=3. busy drops after that cycle.
- D=4, H=4, L=0 → ovf=1, quotient 31, remainder 4. A following start with D=1, H=0, L=17 clears ovf and returns quotient 17, remainder 0.
- start held high throughout an operation → exactly one operation; start is re-accepted only in IDLE; results are unchanged from the single-pulse case.
- rst driven low at S+6 mid-ITER → all outputs 0 immediately (asynchronous). After release, a fresh start with D=13, H=6, L=9 yields 15 and 6 at correct latency.

Source files
------------

// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM encoding, default operand
// width and the iteration-counter sizing helper.
package restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 5;

  function automatic int cntWidth(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cntWidth(DEFAULT_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    CHECK,
    ITER,
    OUT_Q,
    OUT_R
  } state_t;

endpackage

// File: rtl/divider_controller.sv
// Sequencing FSM and iteration counter; emits datapath strobes and the
// registered done/busy handshake.
module divider_controller
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_skip,
  output logic o_loadD,
  output logic o_loadH,
  output logic o_loadL,
  output logic o_check,
  output logic o_shift,
  output logic o_outQ,
  output logic o_outR,
  output logic o_done,
  output logic o_busy
);

  localparam int CW = cntWidth(WIDTH);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_done;
  logic          r_busy;
  logic          w_last;

  always_comb begin
    w_last  = (r_count == CW'(WIDTH - 1));
    o_loadD = (r_state == IDLE) && i_start;
    o_loadH = (r_state == LOAD_HI);
    o_loadL = (r_state == LOAD_LO);
    o_check = (r_state == CHECK);
    o_shift = (r_state == ITER);
    o_outQ  = ((r_state == CHECK) && i_skip) || ((r_state == ITER) && w_last);
    o_outR  = (r_state == OUT_Q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= o_outQ;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= LOAD_HI;
            r_busy  <= 1'b1;
          end
        end
        LOAD_HI: r_state <= LOAD_LO;
        LOAD_LO: r_state <= CHECK;
        CHECK: begin
          r_count <= '0;
          r_state <= i_skip ? OUT_Q : ITER;
        end
        ITER: begin
          if (w_last) begin
            r_state <= OUT_Q;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        OUT_Q: r_state <= OUT_R;
        OUT_R: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_done = r_done;
  assign o_busy = r_busy;

endmodule

// File: rtl/divider_datapath.sv
// Operand registers, one-bit-per-cycle restoring step, status flags and the
// registered word-serial output mux.
module divider_datapath
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_loadD,
  input  logic             i_loadH,
  input  logic             i_loadL,
  input  logic             i_check,
  input  logic             i_shift,
  input  logic             i_outQ,
  input  logic             i_outR,
  output logic             o_skip,
  output logic [WIDTH-1:0] o_dataOut,
  output logic             o_ovf,
  output logic             o_dvz
);

  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dataOut;
  logic             r_ovf;
  logic             r_dvz;

  logic [WIDTH:0]   w_remShift;
  logic [WIDTH+1:0] w_trial;
  logic [WIDTH:0]   w_remNext;
  logic [WIDTH-1:0] w_quoNext;
  logic             w_divZero;
  logic             w_overflow;

  // The remainder register already holds {0,H} once the high word is loaded,
  // so its low word doubles as H for the overflow test and the skip-path remainder.
  always_comb begin
    w_divZero  = (r_divisor == '0);
    w_overflow = !w_divZero && (r_rem[WIDTH-1:0] >= r_divisor);
    o_skip     = w_divZero || w_overflow;
    w_remShift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_trial    = {1'b0, w_remShift} - {2'b00, r_divisor};
    w_remNext  = r_rem;
    w_quoNext  = r_quo;
    if (i_loadH) begin
      w_remNext = {1'b0, i_data};
    end
    if (i_loadL) begin
      w_quoNext = i_data;
    end
    if (i_check && o_skip) begin
      w_quoNext = '1;
    end
    if (i_shift) begin
      if (!w_trial[WIDTH+1]) begin
        w_remNext = w_trial[WIDTH:0];
        w_quoNext = {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        w_remNext = w_remShift;
        w_quoNext = {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dataOut <= '0;
      r_ovf     <= 1'b0;
      r_dvz     <= 1'b0;
    end else begin
      r_rem <= w_remNext;
      r_quo <= w_quoNext;
      if (i_loadD) begin
        r_divisor <= i_data;
        r_ovf     <= 1'b0;
        r_dvz     <= 1'b0;
      end else if (i_check) begin
        r_dvz <= w_divZero;
        r_ovf <= w_overflow;
      end
      // Quotient is taken from the value being written this edge so it lines up with done.
      if (i_outQ) begin
        r_dataOut <= w_quoNext;
      end else if (i_outR) begin
        r_dataOut <= r_rem[WIDTH-1:0];
      end else begin
        r_dataOut <= '0;
      end
    end
  end

  assign o_dataOut = r_dataOut;
  assign o_ovf     = r_ovf;
  assign o_dvz     = r_dvz;

endmodule

// File: rtl/restoring_divider.sv
// Word-serial unsigned restoring divider: D, H, L in; quotient then remainder out.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             busy,
  output logic             ovf,
  output logic             dvz
);

  logic w_loadD;
  logic w_loadH;
  logic w_loadL;
  logic w_check;
  logic w_shift;
  logic w_outQ;
  logic w_outR;
  logic w_skip;

  divider_controller #(.WIDTH(WIDTH)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .i_start (start),
    .i_skip  (w_skip),
    .o_loadD (w_loadD),
    .o_loadH (w_loadH),
    .o_loadL (w_loadL),
    .o_check (w_check),
    .o_shift (w_shift),
    .o_outQ  (w_outQ),
    .o_outR  (w_outR),
    .o_done  (done),
    .o_busy  (busy)
  );

  divider_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .i_data    (data_in),
    .i_loadD   (w_loadD),
    .i_loadH   (w_loadH),
    .i_loadL   (w_loadL),
    .i_check   (w_check),
    .i_shift   (w_shift),
    .i_outQ    (w_outQ),
    .i_outR    (w_outR),
    .o_skip    (w_skip),
    .o_dataOut (data_out),
    .o_ovf     (ovf),
    .o_dvz     (dvz)
  );

endmodule

// File: tb/tb_restoring_divider.sv
// Directed-vector bench for restoring_divider with hand-computed quotients and remainders.
module tb_restoring_divider;

  localparam int W = 5;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         done;
  logic         busy;
  logic         ovf;
  logic         dvz;

  int checks;
  int errors;

  restoring_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done),
    .busy     (busy),
    .ovf      (ovf),
    .dvz      (dvz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge while the DUT is idle; that cycle becomes S.
  // Returns at the negedge of S+11 (back in IDLE) with start left at 'hold'.
  task automatic applyStimulus(input string name, input logic [W-1:0] d, input logic [W-1:0] h,
                               input logic [W-1:0] l, input bit hold, input logic [W-1:0] expQ,
                               input logic [W-1:0] expR, input logic expOvf, input logic expDvz);
    int lat;
    lat = (expOvf || expDvz) ? 1 : 1 + W;
    start   = 1'b1;
    data_in = d;
    @(negedge clk);
    start   = hold;
    data_in = h;
    checkOutput({name, " busy@S+1"}, busy, 1);
    checkOutput({name, " flags cleared@S+1"}, {ovf, dvz}, 0);
    @(negedge clk);
    data_in = l;
    @(negedge clk);
    data_in = '0;
    for (int i = 1; i < lat; i++) @(negedge clk);
    checkOutput({name, " done before quotient"}, done, 0);
    @(negedge clk);
    checkOutput({name, " done@Q"}, done, 1);
    checkOutput({name, " quotient"}, data_out, expQ);
    checkOutput({name, " ovf"}, ovf, expOvf);
    checkOutput({name, " dvz"}, dvz, expDvz);
    @(negedge clk);
    checkOutput({name, " done@R"}, done, 0);
    checkOutput({name, " remainder"}, data_out, expR);
    checkOutput({name, " busy@R"}, busy, 1);
    @(negedge clk);
    checkOutput({name, " busy after R"}, busy, 0);
    checkOutput({name, " data_out idle"}, data_out, 0);
    checkOutput({name, " flags held"}, {ovf, dvz}, {30'd0, expOvf, expDvz});
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    start   = 1'b0;
    data_in = '0;
    #2;
    checkOutput("reset data_out", data_out, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset ovf", ovf, 0);
    checkOutput("reset dvz", dvz, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] basic divide 201/13");
    applyStimulus("div201", 5'd13, 5'd6, 5'd9, 1'b0, 5'd15, 5'd6, 1'b0, 1'b0);
    $display("[TB] maximum legal quotient 991/31");
    applyStimulus("div991", 5'd31, 5'd30, 5'd31, 1'b0, 5'd31, 5'd30, 1'b0, 1'b0);
    $display("[TB] divide by zero");
    applyStimulus("dvz", 5'd0, 5'd3, 5'd7, 1'b0, 5'd31, 5'd3, 1'b0, 1'b1);
    $display("[TB] quotient overflow then clean divide");
    applyStimulus("ovf", 5'd4, 5'd4, 5'd0, 1'b0, 5'd31, 5'd4, 1'b1, 1'b0);
    applyStimulus("after ovf", 5'd1, 5'd0, 5'd17, 1'b0, 5'd17, 5'd0, 1'b0, 1'b0);

    $display("[TB] start held high across an operation");
    applyStimulus("held", 5'd13, 5'd6, 5'd9, 1'b1, 5'd15, 5'd6, 1'b0, 1'b0);
    applyStimulus("back-to-back", 5'd13, 5'd6, 5'd9, 1'b0, 5'd15, 5'd6, 1'b0, 1'b0);
    start = 1'b0;
    @(negedge clk);
    checkOutput("no extra op busy", busy, 0);

    $display("[TB] asynchronous reset mid-iteration");
    start   = 1'b1;
    data_in = 5'd13;
    @(negedge clk);
    start   = 1'b0;
    data_in = 5'd6;
    @(negedge clk);
    data_in = 5'd9;
    @(negedge clk);
    data_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("busy before reset", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset done", done, 0);
    checkOutput("async reset data_out", data_out, 0);
    checkOutput("async reset flags", {ovf, dvz}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus("post-reset", 5'd13, 5'd6, 5'd9, 1'b0, 5'd15, 5'd6, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
